uart_si_param: RTL and testbench
================================

// Module: uart_si_param
// PURPOSE
//  Parametrised UART peripheral on the simple bus (addr/we/wd/rd): full-duplex TX+RX, separate TX/RX FIFOs.
//  Adds a mid-bit-sampling receiver, a status register, sticky error flags and an interrupt line.
//  Sits on the peripheral bus next to the other simple-interface peripherals; one instance per UART port.
// PARAMETERS
//  DATA_W      8  frame data bits, legal 5..9
//  TX_DEPTH    8  TX FIFO entries, power of 2, >=2
//  RX_DEPTH    8  RX FIFO entries, power of 2, >=2
//  SYNC_STAGES 2  uart_rx synchroniser flops, >=2
// PORTS
//  clk      in   1   clock
//  rst      in   1   asynchronous reset, active-high
//  addr     in   4   register address
//  we       in   1   write strobe
//  re       in   1   read strobe (pops RX FIFO at TX_RX only)
//  wd       in   32  write data
//  rd       out  32  read data, combinational from addr
//  irq      out  1   interrupt, level
//  uart_tx  out  1   serial out, idle high
//  uart_rx  in   1   serial in, asynchronous
// BEHAVIOUR
//  Map:   0x0 CR  0x4 TX_RX  0x8 DR  0xC SR. Other addresses read 0, writes ignored.
//  CR:    [0] tx_en  [1] rx_en  [2] rie  [3] tie  [5] par_en  [6] par_odd.
//         Writing 1 to [7] clears rx_ovf, frm_err and par_err (self-clearing, reads 0).
//  DR:    [15:0] udvr. Bit period = udvr+1 clk.
//  SR:    [0] tx_busy  [1] tx_full  [2] tx_emp  [3] rx_full  [4] rx_emp  [5] rx_ovf  [6] frm_err  [7] par_err.
//  Reset: all regs 0. uart_tx=1, irq=0, FIFOs empty (SR=0x14). Both FSMs IDLE, counters 0.
//  Write TX_RX: pushes wd[DATA_W-1:0] if !tx_full; when full the data is dropped and no flag is set.
//  Read TX_RX: rd = zero-extended RX head (0 if empty).
//         re && addr==0x4 && !rx_emp pops at the clock edge. rd holds the popped value for that cycle.
//  TX FSM IDLE->START->DATA->[PAR]->STOP->IDLE. Each state lasts one bit period. DATA is LSB first, DATA_W bits.
//         Leaves IDLE when tx_en && !tx_emp; pops TX FIFO on the IDLE->START edge.
//         From STOP, chains directly to START if a word is pending: no idle bit.
//         tx_en cleared mid-frame: the current frame completes, then IDLE.
//         tx_busy=1 in every state except IDLE.
//  RX:    uart_rx passes SYNC_STAGES flops. Any path of RX or TX FSMs is held in IDLE while rx_en/tx_en=0.
//  RX FSM IDLE->START->DATA->[PAR]->STOP->IDLE.
//         IDLE: a falling edge of the synchronised rx starts a frame.
//         START: wait udvr/2+1 clk; if line high -> IDLE (false start, nothing recorded). Otherwise sample every udvr+1 clk.
//         STOP: sample=0 sets frm_err and discards the byte. Sample=1 with a parity mismatch sets par_err and discards.
//         Otherwise push the byte; if rx_full the byte is discarded and rx_ovf is set.
//         A push and a pop in the same cycle on a full FIFO: pop first, push accepted, no rx_ovf.
//         rx_en cleared mid-frame: RX FSM -> IDLE next cycle, partial byte discarded.
//  Flags: rx_ovf/frm_err/par_err are sticky until the CR[7] clear.
//         A flag set and a clear in the same cycle: the set wins.
//  irq = (rie && !rx_emp) || (tie && tx_emp && !tx_busy), registered (1-clk latency).
//  udvr written mid-frame: takes effect at the next bit boundary.
//  rst asserted mid-frame: immediate return to reset state, uart_tx=1.
// CONFIGURATION
//  UART_PARITY_EN defined:
//    PAR states exist. TX sends even parity, or odd when par_odd=1, if par_en=1. RX checks it.
//  Not defined:
//    no PAR states, CR[6:5] read 0 and writes to them are ignored, SR[7]=0. Frame = 1 start + DATA_W data + 1 stop.
// TESTING
//  1 Reset: rst pulse mid-frame -> uart_tx=1, SR=0x14, CR/DR=0, irq=0 next cycle.
//  2 TX: DR=3, CR=1, write 0x55 -> start bit low 4 clk, bits 1,0,1,0,1,0,1,0 of 4 clk each, stop high.
//    Total frame 40 clk; SR.tx_busy=0 after.
//  3 TX backpressure: TX_DEPTH+1 writes with tx_en=0 -> tx_full=1, last word lost.
//    Then tx_en=1 -> TX_DEPTH back-to-back frames, no gap.
//  4 RX: DR=7, CR=2, drive 0xA3 at 8 clk/bit -> rx_emp=0. Read with re -> rd=0xA3, then rx_emp=1.
//    A 3-clk low glitch gives no byte.
//  5 Errors: stop bit 0 -> frm_err=1, no byte. RX_DEPTH+1 frames unread -> rx_ovf=1.
//    CR[7] write clears both flags; the FIFO is still full.
//  6 UART_PARITY_EN build: par_en=1, par_odd=0; TX 0x07 -> parity bit 1.
//    RX frame with a wrong parity bit -> par_err=1, byte dropped. Non-parity build: CR=0x60 reads 0x00.

Source files
------------

// File: rtl/uart_si_param.sv
// -----------------------------------------------------------------------------
// uart_si_param
// Full-duplex UART peripheral on the simple register bus (addr/we/re/wd/rd).
// It has a TX FIFO feeding a serialiser and a mid-bit-sampling receiver feeding
// an RX FIFO. It also provides a status register, sticky error flags and a
// registered level interrupt.
//
// Build option: define UART_PARITY_EN to add the parity bit state to both
// FSMs. It also adds the CR par_en/par_odd bits and the SR par_err flag.
// Without it, frames are 1 start + DATA_W data + 1 stop. CR[6:5] and SR[7]
// then read 0.
//
// Ports:
//   clk      clock
//   rst      asynchronous reset, active-high
//   addr     register address (0x0 CR, 0x4 TX_RX, 0x8 DR, 0xC SR)
//   we       write strobe
//   re       read strobe (pops RX FIFO when addr is TX_RX)
//   wd       write data
//   rd       read data, combinational from addr
//   irq      level interrupt, registered
//   uart_tx  serial output, idle high
//   uart_rx  serial input, asynchronous to clk
//
// Bus handshake: there is no wait state. A write takes effect at the clock
// edge where we=1. A read returns data combinationally in the same cycle. The
// RX pop happens at the edge where re=1 and addr selects TX_RX and the FIFO is
// not empty.
// -----------------------------------------------------------------------------
module uart_si_param #(
  parameter int DATA_W      = 8,
  parameter int TX_DEPTH    = 8,
  parameter int RX_DEPTH    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  addr,
  input  logic        we,
  input  logic        re,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        irq,
  output logic        uart_tx,
  input  logic        uart_rx
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam logic [3:0] LAST_BIT = 4'(DATA_W - 1);

  localparam logic [3:0] A_CR   = 4'h0;
  localparam logic [3:0] A_TXRX = 4'h4;
  localparam logic [3:0] A_DR   = 4'h8;
  localparam logic [3:0] A_SR   = 4'hC;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4
  } state_e;

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic        tx_en_q, rx_en_q, rie_q, tie_q;
  logic        par_en, par_odd;
  logic [15:0] dr_q;

  logic cr_wr, txrx_wr, dr_wr, flag_clr, rx_pop;

  assign cr_wr    = we && (addr == A_CR);
  assign txrx_wr  = we && (addr == A_TXRX);
  assign dr_wr    = we && (addr == A_DR);
  assign flag_clr = cr_wr && wd[7];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_en_q <= 1'b0;
      rx_en_q <= 1'b0;
      rie_q   <= 1'b0;
      tie_q   <= 1'b0;
      dr_q    <= 16'd0;
    end else begin
      if (cr_wr) begin
        tx_en_q <= wd[0];
        rx_en_q <= wd[1];
        rie_q   <= wd[2];
        tie_q   <= wd[3];
      end
      if (dr_wr) dr_q <= wd[15:0];
    end
  end

`ifdef UART_PARITY_EN
  logic par_en_q, par_odd_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
    end else if (cr_wr) begin
      par_en_q  <= wd[5];
      par_odd_q <= wd[6];
    end
  end
  assign par_en  = par_en_q;
  assign par_odd = par_odd_q;
`else
  assign par_en  = 1'b0;
  assign par_odd = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // TX FIFO: pointers carry one extra wrap bit to tell full from empty
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] tx_mem_q [TX_DEPTH];
  logic [TX_AW:0]    tx_wptr_q, tx_rptr_q;
  logic              tx_emp, tx_full, tx_push, tx_pop;
  logic [DATA_W-1:0] tx_head;

  assign tx_emp  = (tx_wptr_q == tx_rptr_q);
  assign tx_full = (tx_wptr_q[TX_AW] != tx_rptr_q[TX_AW]) &&
                   (tx_wptr_q[TX_AW-1:0] == tx_rptr_q[TX_AW-1:0]);
  assign tx_push = txrx_wr && !tx_full;   // full: word silently dropped
  assign tx_head = tx_mem_q[tx_rptr_q[TX_AW-1:0]];

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wptr_q[TX_AW-1:0]] <= wd[DATA_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
    end else begin
      if (tx_push) tx_wptr_q <= tx_wptr_q + 1'b1;
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // TX FSM. Each state lasts dr_q+1 clocks. The bit counter reloads from dr_q
  // at every bit boundary, so a DR write takes effect on the next bit.
  // ---------------------------------------------------------------------------
  state_e            tx_state_q, tx_state_d;
  logic [15:0]       tx_cnt_q, tx_cnt_d;
  logic [3:0]        tx_bit_q, tx_bit_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic              tx_par_q, tx_par_d;
  logic              tx_line_q, tx_line_d;
  logic              tx_load, tx_busy, tx_end;

  assign tx_end  = (tx_cnt_q == 16'd0);
  assign tx_busy = (tx_state_q != S_IDLE);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_load    = 1'b0;
    tx_line_d  = 1'b1;

    case (tx_state_q)
      S_IDLE: begin
        tx_load = tx_en_q && !tx_emp;
      end
      S_START: begin
        if (tx_end) begin
          tx_state_d = S_DATA;
          tx_bit_d   = 4'd0;
          tx_cnt_d   = dr_q;
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (tx_end) begin
          tx_cnt_d = dr_q;
          if (tx_bit_q == LAST_BIT) begin
            tx_state_d = par_en ? S_PAR : S_STOP;
          end else begin
            tx_bit_d   = tx_bit_q + 4'd1;
            tx_shift_d = tx_shift_q >> 1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
`ifdef UART_PARITY_EN
      S_PAR: begin
        if (tx_end) begin
          tx_state_d = S_STOP;
          tx_cnt_d   = dr_q;
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
`endif
      S_STOP: begin
        if (tx_end) begin
          // Chain straight into the next start bit when a word is waiting.
          tx_load = tx_en_q && !tx_emp;
          if (!tx_load) begin
            tx_state_d = S_IDLE;
            tx_cnt_d   = 16'd0;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      default: begin
        tx_state_d = S_IDLE;
        tx_cnt_d   = 16'd0;
      end
    endcase

    if (tx_load) begin
      tx_state_d = S_START;
      tx_shift_d = tx_head;
      tx_par_d   = (^tx_head) ^ par_odd;
      tx_cnt_d   = dr_q;
    end

    // Line level is registered together with the state so uart_tx is glitch free.
    case (tx_state_d)
      S_START: tx_line_d = 1'b0;
      S_DATA:  tx_line_d = tx_shift_d[0];
      S_PAR:   tx_line_d = tx_par_d;
      default: tx_line_d = 1'b1;
    endcase
  end

  assign tx_pop = tx_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= 16'd0;
      tx_bit_q   <= 4'd0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_line_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_line_q  <= tx_line_d;
    end
  end

  assign uart_tx = tx_line_q;

  // ---------------------------------------------------------------------------
  // RX synchroniser. Flops reset to the idle-high level so that reset release
  // cannot fake a falling edge.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] rx_sync_q;
  logic                   rx_prev_q, rx_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sync_q <= '1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_sync_q <= {rx_sync_q[SYNC_STAGES-2:0], uart_rx};
      rx_prev_q <= rx_s;
    end
  end

  assign rx_s = rx_sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // RX FSM. START waits half a bit (dr_q/2+1 clocks) to land mid-bit. Every
  // later sample is one full bit period apart.
  // ---------------------------------------------------------------------------
  state_e            rx_state_q, rx_state_d;
  logic [15:0]       rx_cnt_q, rx_cnt_d;
  logic [3:0]        rx_bit_q, rx_bit_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic              rx_par_q, rx_par_d;
  logic              rx_end, rx_push, set_frm, set_par;

  assign rx_end = (rx_cnt_q == 16'd0);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_par_d   = rx_par_q;
    rx_push    = 1'b0;
    set_frm    = 1'b0;
    set_par    = 1'b0;

    case (rx_state_q)
      S_IDLE: begin
        if (rx_prev_q && !rx_s) begin
          rx_state_d = S_START;
          rx_cnt_d   = {1'b0, dr_q[15:1]};
        end
      end
      S_START: begin
        if (rx_end) begin
          if (rx_s) begin
            rx_state_d = S_IDLE;          // false start
          end else begin
            rx_state_d = S_DATA;
            rx_bit_d   = 4'd0;
            rx_cnt_d   = dr_q;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (rx_end) begin
          rx_shift_d = {rx_s, rx_shift_q[DATA_W-1:1]};
          rx_cnt_d   = dr_q;
          if (rx_bit_q == LAST_BIT) begin
            rx_state_d = par_en ? S_PAR : S_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 4'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
`ifdef UART_PARITY_EN
      S_PAR: begin
        if (rx_end) begin
          rx_par_d   = rx_s;
          rx_state_d = S_STOP;
          rx_cnt_d   = dr_q;
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
`endif
      S_STOP: begin
        if (rx_end) begin
          rx_state_d = S_IDLE;
          rx_cnt_d   = 16'd0;
          if (!rx_s) begin
            set_frm = 1'b1;
          end else if (par_en && (rx_par_q != ((^rx_shift_q) ^ par_odd))) begin
            set_par = 1'b1;
          end else begin
            rx_push = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      default: begin
        rx_state_d = S_IDLE;
        rx_cnt_d   = 16'd0;
      end
    endcase

    // Disabling the receiver abandons any partial frame immediately.
    if (!rx_en_q) begin
      rx_state_d = S_IDLE;
      rx_cnt_d   = 16'd0;
      rx_push    = 1'b0;
      set_frm    = 1'b0;
      set_par    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= 16'd0;
      rx_bit_q   <= 4'd0;
      rx_shift_q <= '0;
      rx_par_q   <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_par_q   <= rx_par_d;
    end
  end

  // ---------------------------------------------------------------------------
  // RX FIFO. A pop in the same cycle frees the slot for a push into a full FIFO.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] rx_mem_q [RX_DEPTH];
  logic [RX_AW:0]    rx_wptr_q, rx_rptr_q;
  logic              rx_emp, rx_full, rx_wr, set_ovf;
  logic [DATA_W-1:0] rx_head;

  assign rx_emp  = (rx_wptr_q == rx_rptr_q);
  assign rx_full = (rx_wptr_q[RX_AW] != rx_rptr_q[RX_AW]) &&
                   (rx_wptr_q[RX_AW-1:0] == rx_rptr_q[RX_AW-1:0]);
  assign rx_pop  = re && (addr == A_TXRX) && !rx_emp;
  assign rx_wr   = rx_push && (!rx_full || rx_pop);
  assign set_ovf = rx_push && rx_full && !rx_pop;
  assign rx_head = rx_mem_q[rx_rptr_q[RX_AW-1:0]];

  always_ff @(posedge clk) begin
    if (rx_wr) rx_mem_q[rx_wptr_q[RX_AW-1:0]] <= rx_shift_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
    end else begin
      if (rx_wr)  rx_wptr_q <= rx_wptr_q + 1'b1;
      if (rx_pop) rx_rptr_q <= rx_rptr_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags: a set in the same cycle as a clear wins.
  // ---------------------------------------------------------------------------
  logic rx_ovf_q, frm_err_q, par_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_ovf_q  <= 1'b0;
      frm_err_q <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      rx_ovf_q  <= set_ovf | (rx_ovf_q  & ~flag_clr);
      frm_err_q <= set_frm | (frm_err_q & ~flag_clr);
      par_err_q <= set_par | (par_err_q & ~flag_clr);
    end
  end

  // ---------------------------------------------------------------------------
  // Interrupt (one clock of latency)
  // ---------------------------------------------------------------------------
  logic irq_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= (rie_q && !rx_emp) || (tie_q && tx_emp && !tx_busy);
  end

  assign irq = irq_q;

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    rd = 32'd0;
    case (addr)
      A_CR:   rd = {24'd0, 1'b0, par_odd, par_en, 1'b0, tie_q, rie_q, rx_en_q, tx_en_q};
      A_TXRX: rd = rx_emp ? 32'd0 : {{(32-DATA_W){1'b0}}, rx_head};
      A_DR:   rd = {16'd0, dr_q};
      A_SR:   rd = {24'd0, par_err_q, frm_err_q, rx_ovf_q, rx_emp, rx_full,
                    tx_emp, tx_full, tx_busy};
      default: rd = 32'd0;
    endcase
  end

  // Bits of the write bus that no register stores.
  logic unused_wd;
  assign unused_wd = ^{wd[31:16], wd[6:4]};

endmodule

// File: tb/tb_uart_si_param.sv
// -----------------------------------------------------------------------------
// tb_uart_si_param
// Directed bench for uart_si_param with the default parameters. It covers reset,
// TX framing, TX back-pressure and back-to-back frames, RX reception and false
// start, framing error, overflow, flag clear and interrupts. It also covers the
// parity behaviour of whichever build is compiled.
// -----------------------------------------------------------------------------
module tb_uart_si_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  addr = 4'h0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [31:0] wd = 32'd0;
  logic [31:0] rd;
  logic        irq;
  logic        uart_tx;
  logic        uart_rx = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  uart_si_param #(
    .DATA_W(8), .TX_DEPTH(8), .RX_DEPTH(8), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst(rst), .addr(addr), .we(we), .re(re), .wd(wd),
    .rd(rd), .irq(irq), .uart_tx(uart_tx), .uart_rx(uart_rx)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wd = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0; wd = 32'd0; addr = 4'h0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a;
    #1 d = rd;
  endtask

  task automatic pop_read(output logic [31:0] d);
    @(negedge clk);
    addr = 4'h4; re = 1'b1;
    #1 d = rd;
    @(negedge clk);
    re = 1'b0; addr = 4'h0;
  endtask

  task automatic wait_tx_fall(input int max_cyc, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (uart_tx == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Serial frame on uart_rx, bit_clk clocks per bit, LSB first.
  task automatic drive_rx(input logic [7:0] data, input int bit_clk,
                          input logic use_par, input logic par, input logic stop);
    uart_rx = 1'b0;
    repeat (bit_clk) @(negedge clk);
    for (int b = 0; b < 8; b++) begin
      uart_rx = data[b];
      repeat (bit_clk) @(negedge clk);
    end
    if (use_par) begin
      uart_rx = par;
      repeat (bit_clk) @(negedge clk);
    end
    uart_rx = stop;
    repeat (bit_clk) @(negedge clk);
    uart_rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] v;
  logic        ok;
  int          bad;
  logic [9:0]  frame_55;
  logic [9:0]  fr;
`ifdef UART_PARITY_EN
  logic [10:0] frame_07p;
`endif

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bus_read(4'hC, v); check_eq("reset_sr", v, 32'h14);
    bus_read(4'h0, v); check_eq("reset_cr", v, 32'h0);
    bus_read(4'h8, v); check_eq("reset_dr", v, 32'h0);
    check_eq("reset_irq", {31'd0, irq}, 32'd0);
    check_eq("reset_tx", {31'd0, uart_tx}, 32'd1);

    // TX single frame 0x55, 4 clk per bit
    bus_write(4'h8, 32'd3);
    bus_read(4'h8, v); check_eq("dr_readback", v, 32'd3);
    bus_write(4'h0, 32'h1);
    bus_write(4'h4, 32'h55);
    wait_tx_fall(10, ok);
    check_eq("tx55_start_seen", {31'd0, ok}, 32'd1);
    frame_55 = 10'b1010101010;   // index 0 = start, 1..8 = data LSB first, 9 = stop
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clk);
      if (uart_tx !== frame_55[i/4]) bad++;
    end
    check_eq("tx55_wave_errs", bad, 0);
    bus_read(4'hC, v); check_eq("tx55_done_sr", v, 32'h14);
    check_eq("tx55_idle_line", {31'd0, uart_tx}, 32'd1);

    // TX back-pressure: 9 writes while disabled, 9th lost
    bus_write(4'h0, 32'h0);
    for (int i = 0; i < 9; i++) bus_write(4'h4, 32'h10 + i);
    bus_read(4'hC, v); check_eq("txbp_full_sr", v, 32'h12);
    bus_write(4'h0, 32'h1);
    wait_tx_fall(10, ok);
    check_eq("txbp_start_seen", {31'd0, ok}, 32'd1);
    bad = 0;
    for (int i = 0; i < 8 * 40; i++) begin
      if (i > 0) @(negedge clk);
      fr = {1'b1, 8'(8'h10 + i / 40), 1'b0};
      if (uart_tx !== fr[(i % 40) / 4]) bad++;
    end
    check_eq("txbp_wave_errs", bad, 0);
    bus_read(4'hC, v); check_eq("txbp_drained_sr", v, 32'h14);
    repeat (10) @(negedge clk);
    check_eq("txbp_no_9th", {31'd0, uart_tx}, 32'd1);

    // RX 0xA3 at 8 clk/bit
    bus_write(4'h8, 32'd7);
    bus_write(4'h0, 32'h2);
    drive_rx(8'hA3, 8, 1'b0, 1'b0, 1'b1);
    bus_read(4'hC, v); check_eq("rx_avail_sr", v, 32'h04);
    pop_read(v); check_eq("rx_data_a3", v, 32'hA3);
    bus_read(4'hC, v); check_eq("rx_popped_sr", v, 32'h14);
    bus_read(4'h4, v); check_eq("rx_empty_rd", v, 32'h0);

    // 3-clk glitch: false start
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    repeat (100) @(negedge clk);
    bus_read(4'hC, v); check_eq("rx_glitch_sr", v, 32'h14);

    // Framing error
    drive_rx(8'h5A, 8, 1'b0, 1'b0, 1'b0);
    bus_read(4'hC, v); check_eq("rx_frm_sr", v, 32'h54);

    // Overflow: 9 frames unread
    for (int i = 0; i < 9; i++) drive_rx(8'(i + 1), 8, 1'b0, 1'b0, 1'b1);
    bus_read(4'hC, v); check_eq("rx_ovf_sr", v, 32'h6C);
    bus_write(4'h0, 32'h82);
    bus_read(4'hC, v); check_eq("flag_clr_sr", v, 32'h0C);
    bus_read(4'h0, v); check_eq("cr_bit7_reads0", v, 32'h02);
    bus_read(4'h4, v); check_eq("rx_head_no_pop", v, 32'h01);

    // RX interrupt
    bus_write(4'h0, 32'h06);
    @(negedge clk);
    check_eq("irq_rie", {31'd0, irq}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      pop_read(v);
      check_eq($sformatf("rx_drain_%0d", i), v, 32'(i + 1));
    end
    bus_read(4'hC, v); check_eq("rx_drained_sr", v, 32'h14);
    @(negedge clk);
    check_eq("irq_rie_empty", {31'd0, irq}, 32'd0);

    // TX interrupt
    bus_write(4'h0, 32'h09);
    @(negedge clk);
    check_eq("irq_tie", {31'd0, irq}, 32'd1);

`ifdef UART_PARITY_EN
    // TX 0x07 with even parity: parity bit 1
    bus_write(4'h8, 32'd3);
    bus_write(4'h0, 32'h21);
    bus_write(4'h4, 32'h07);
    wait_tx_fall(10, ok);
    check_eq("txpar_start_seen", {31'd0, ok}, 32'd1);
    frame_07p = 11'b11000001110;
    bad = 0;
    for (int i = 0; i < 44; i++) begin
      if (i > 0) @(negedge clk);
      if (uart_tx !== frame_07p[i/4]) bad++;
    end
    check_eq("txpar_wave_errs", bad, 0);
    // RX with wrong parity bit
    bus_write(4'h8, 32'd7);
    bus_write(4'h0, 32'h22);
    drive_rx(8'h07, 8, 1'b1, 1'b0, 1'b1);
    bus_read(4'hC, v); check_eq("rxpar_err_sr", v, 32'h94);
`else
    bus_write(4'h0, 32'h60);
    bus_read(4'h0, v); check_eq("cr_nopar_reads0", v, 32'h00);
`endif

    // Reset in the middle of a TX frame
    bus_write(4'h8, 32'd3);
    bus_write(4'h0, 32'h09);
    bus_write(4'h4, 32'hFF);
    bus_write(4'h4, 32'h00);
    wait_tx_fall(10, ok);
    check_eq("rstmid_start_seen", {31'd0, ok}, 32'd1);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    addr = 4'hC;
    #1;
    check_eq("rstmid_tx", {31'd0, uart_tx}, 32'd1);
    check_eq("rstmid_sr", rd, 32'h14);
    check_eq("rstmid_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus_read(4'h0, v); check_eq("rstmid_cr", v, 32'h0);
    bus_read(4'h8, v); check_eq("rstmid_dr", v, 32'h0);
    check_eq("rstmid_irq_after", {31'd0, irq}, 32'd0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) bad++;
    end
    check_eq("rstmid_line_idle", bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
